// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// Multi-cycle control sequencer for a reduced RISC-V datapath that executes
// only addi and bne. It owns the PC and the instruction register. It fetches
// over a req/ack instruction-memory handshake and decodes the fetched word.
// It drives the register-file addresses, the immediate and the ALU controls.
// Branches resolve from the ALU eq flag.
//
// Ports:
//   clk, rst          clock (rising edge) / asynchronous active-low reset
//   start             one-cycle pulse, leaves IDLE
//   imem_req/addr     fetch request and address (= pc)
//   imem_ack/rdata    fetch completion and instruction word
//   rs1, rs2, rd      register-file addresses decoded from ir
//   imm_ext           sign-extended immediate (I-type, or B-type for bne)
//   alu_src           1 = ALU op2 is imm_ext, 0 = register rs2
//   ALU_ctrl          0 = add, 1 = compare
//   reg_write         register-file write enable (EXECUTE of addi, rd != 0)
//   eq                ALU compare flag, sampled at the end of EXECUTE
//   pc, busy, trap    program counter, activity flag, sticky fault flag
//   retired           wrapping count of completed instructions
module rv_multicycle_ctrl #(
  parameter int                    Data_Width    = 32,
  parameter int                    Address_Width = 5,
  parameter logic [Data_Width-1:0] PC_RESET      = '0,
  parameter int                    CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     imem_req,
  output logic [Data_Width-1:0]    imem_addr,
  input  logic                     imem_ack,
  input  logic [Data_Width-1:0]    imem_rdata,
  output logic [Address_Width-1:0] rs1,
  output logic [Address_Width-1:0] rs2,
  output logic [Address_Width-1:0] rd,
  output logic [Data_Width-1:0]    imm_ext,
  output logic                     alu_src,
  output logic                     ALU_ctrl,
  output logic                     reg_write,
  input  logic                     eq,
  output logic [Data_Width-1:0]    pc,
  output logic                     busy,
  output logic                     trap,
  output logic [CNT_W-1:0]         retired
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    TRAP    = 3'd4
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t                  state_reg, state_next;
  logic [Data_Width-1:0]   pc_reg, pc_next;
  logic [Data_Width-1:0]   ir_reg, ir_next;
  logic [CNT_W-1:0]        retired_reg, retired_next;
  logic                    trap_reg, trap_next;

  logic                    is_addi;
  logic                    is_bne;
  logic [Data_Width-1:0]   imm_i;
  logic [Data_Width-1:0]   imm_b;
  logic [Data_Width-1:0]   pc_plus4;
  logic [Data_Width-1:0]   br_target;

  // Decode is purely combinational from ir, so the fields stay stable
  // across a stalled fetch because ir only loads on the ack edge.
  assign is_addi = (ir_reg[6:0] == OPC_OP_IMM) && (ir_reg[14:12] == 3'b000);
  assign is_bne  = (ir_reg[6:0] == OPC_BRANCH) && (ir_reg[14:12] == 3'b001);

  assign imm_i = {{(Data_Width-12){ir_reg[31]}}, ir_reg[31:20]};
  assign imm_b = {{(Data_Width-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                  ir_reg[30:25], ir_reg[11:8], 1'b0};

  assign rs1      = ir_reg[19:15];
  assign rs2      = ir_reg[24:20];
  assign rd       = ir_reg[11:7];
  assign imm_ext  = is_bne ? imm_b : imm_i;
  assign ALU_ctrl = is_bne;
  assign alu_src  = ~is_bne;

  // Branch taken when the operands differ (eq == 0).
  assign pc_plus4  = pc_reg + Data_Width'(4);
  assign br_target = eq ? pc_plus4 : (pc_reg + imm_b);

  // Output strobes depend only on the state register, so an asynchronous
  // reset drops them at once without waiting for a clock.
  assign imem_req  = (state_reg == FETCH);
  assign imem_addr = pc_reg;
  assign busy      = (state_reg == FETCH) || (state_reg == DECODE) ||
                     (state_reg == EXECUTE);
  assign reg_write = (state_reg == EXECUTE) && is_addi && (rd != '0);
  assign pc        = pc_reg;
  assign trap      = trap_reg;
  assign retired   = retired_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pc_reg      <= PC_RESET;
      ir_reg      <= '0;
      retired_reg <= '0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      retired_reg <= retired_next;
      trap_reg    <= trap_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    retired_next = retired_reg;
    trap_next    = trap_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_next    = imem_rdata;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (is_addi || is_bne) begin
          state_next = EXECUTE;
        end else begin
          trap_next  = 1'b1;
          state_next = TRAP;
        end
      end
      EXECUTE: begin
        // A misaligned branch target faults before anything commits, so
        // pc keeps the address of the faulting bne.
        if (is_bne && (br_target[1:0] != 2'b00)) begin
          trap_next  = 1'b1;
          state_next = TRAP;
        end else begin
          pc_next      = is_bne ? br_target : pc_plus4;
          retired_next = retired_reg + CNT_W'(1);
          state_next   = FETCH;
        end
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
